ripple_borrow_subtractor: RTL and testbench

Fully pipelined signed/unsigned subtractor computing `diff = a - b - bin`, one difference bit resolved per pipeline stage, with a valid/ready handshake on both ends. It is the subtract-direction counterpart of the pipelined ripple-carry adder and sits beside it in the signed arithmetic datapath. It sustains one operation per clock and stalls the whole pipeline under output backpressure.

---
 rtl/ripple_borrow_subtractor.sv | 85 ++++++++
 tb/tb_ripple_borrow_subtractor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_borrow_subtractor.sv
// rtl/ripple_borrow_subtractor.sv - pipelined a - b - bin, one difference bit per stage
// Optional signed-overflow output enabled by defining RIPPLE_SUB_OVF_EN.
module ripple_borrow_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        // word_q holds resolved difference bits below i and untouched minuend bits from i up.
        logic [WIDTH-1:0]   word_q;
        logic [WIDTH-1-i:0] b_q;
        logic               borrow_q;
        logic               valid_q;
        logic               d;
        logic               bo;
        logic [WIDTH-1:0]   resolved;

        assign d  = word_q[i] ^ b_q[0] ^ borrow_q;
        assign bo = (~word_q[i] & b_q[0]) | (~word_q[i] & borrow_q) | (b_q[0] & borrow_q);

        always_comb begin
            resolved    = word_q;
            resolved[i] = d;
        end

        if (i == 0) begin : g_first
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    word_q   <= '0;
                    b_q      <= '0;
                    borrow_q <= 1'b0;
                    valid_q  <= 1'b0;
                end else if (!stall) begin
                    word_q   <= a;
                    b_q      <= b;
                    borrow_q <= bin;
                    valid_q  <= in_valid & in_ready;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    word_q   <= '0;
                    b_q      <= '0;
                    borrow_q <= 1'b0;
                    valid_q  <= 1'b0;
                end else if (!stall) begin
                    word_q   <= g_stage[i-1].resolved;
                    b_q      <= g_stage[i-1].b_q[WIDTH-i:1];
                    borrow_q <= g_stage[i-1].bo;
                    valid_q  <= g_stage[i-1].valid_q;
                end
            end
        end
    end

    assign out_valid = g_stage[WIDTH-1].valid_q;
    assign diff      = g_stage[WIDTH-1].resolved;
    assign bout      = g_stage[WIDTH-1].bo;

`ifdef RIPPLE_SUB_OVF_EN
    // The last stage's borrow register is the borrow into the MSB.
    assign ovf = g_stage[WIDTH-1].borrow_q ^ g_stage[WIDTH-1].bo;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_borrow_subtractor.sv
// tb/tb_ripple_borrow_subtractor.sv - self-checking bench for ripple_borrow_subtractor
module tb_ripple_borrow_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    ripple_borrow_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc_cyc;
        int           acc_stalls;
    } exp_t;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vbin;
        logic [W-1:0] ed;
        logic         ebo;
        logic         eov;
    } vec_t;

    exp_t         exp_q[$];
    int           n_checks    = 0;
    int           n_fail      = 0;
    int           cyc         = 0;
    int           stall_edges = 0;
    int           n_out       = 0;
    logic [W-1:0] nxt_d;
    logic         nxt_bo;
    logic         nxt_ov;
    logic         accepted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t e;
        int   u;
        int   s;
        u = int'(ma) - int'(mb) - int'(mbin);
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.d  = u[W-1:0];
        e.bo = (u < 0);
`ifdef RIPPLE_SUB_OVF_EN
        e.ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
`else
        e.ov = 1'b0;
`endif
        e.acc_cyc    = 0;
        e.acc_stalls = 0;
        return e;
    endfunction

    task automatic set_in(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
        exp_t e;
        e      = model(va, vb, vbin);
        a      = va;
        b      = vb;
        bin    = vbin;
        nxt_d  = e.d;
        nxt_bo = e.bo;
        nxt_ov = e.ov;
    endtask

    // One clock: sample at negedge, score transfers, return 1 time unit after the posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_out: out_valid=1 diff=0x%0h, required no result (cycle %0d)", diff, cyc);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                chk("diff", diff, e.d);
                chk("bout", bout, e.bo);
                chk("ovf", ovf, e.ov);
                chk("latency", cyc - e.acc_cyc, W + stall_edges - e.acc_stalls);
                n_out++;
            end else begin
                chk("stall_hold_diff", diff, exp_q[0].d);
                chk("stall_in_ready", in_ready, 1'b0);
            end
        end
        if (in_valid && in_ready) begin
            e.d          = nxt_d;
            e.bo         = nxt_bo;
            e.ov         = nxt_ov;
            e.acc_cyc    = cyc;
            e.acc_stalls = stall_edges;
            exp_q.push_back(e);
            accepted = 1'b1;
        end
        if (out_valid && !out_ready) stall_edges++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k        = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && k < budget) begin
            cycle();
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic burst(input int n, input int st, input int sl, input int bubble_pct);
        int           k;
        int           rc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        k    = 0;
        rc   = 0;
        ra   = W'($urandom);
        rb   = W'($urandom);
        rbin = 1'($urandom);
        while (k < n && rc < 1000) begin
            out_ready = !(rc >= st && rc < st + sl);
            set_in(ra, rb, rbin);
            in_valid = ($urandom_range(99) >= bubble_pct);
            cycle();
            rc++;
            if (accepted) begin
                k++;
                ra   = W'($urandom);
                rb   = W'($urandom);
                rbin = 1'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("burst_issued", k, n);
    endtask

    initial begin
        vec_t vecs[8];
        int   n0;
        int   s0;

`ifdef RIPPLE_SUB_OVF_EN
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
`else
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
`endif

        arst_n    = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        nxt_d     = '0;
        nxt_bo    = 1'b0;
        nxt_ov    = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Directed vectors, one at a time, against hand-derived constants.
        for (int i = 0; i < 8; i++) begin
            a        = vecs[i].va;
            b        = vecs[i].vb;
            bin      = vecs[i].vbin;
            nxt_d    = vecs[i].ed;
            nxt_bo   = vecs[i].ebo;
            nxt_ov   = vecs[i].eov;
            in_valid = 1'b1;
            cycle();
            chk("tbl_accept", accepted, 1'b1);
            drain("tbl_drain", 20);
        end

        // Back-to-back burst: every result exactly W clocks after its operand.
        n0 = n_out;
        burst(20, 1000, 0, 0);
        repeat (W) cycle();
        chk("burst_count", n_out - n0, 20);
        chk("burst_empty", exp_q.size(), 0);

        // Burst with three cycles of backpressure while results are present.
        n0 = n_out;
        s0 = stall_edges;
        burst(12, 10, 3, 0);
        drain("stall_drain", 60);
        chk("stall_edges", stall_edges - s0, 3);
        chk("stall_count", n_out - n0, 12);

        // Bubbly input with random backpressure.
        n0 = n_out;
        for (int r = 0; r < 40; r++) begin
            set_in(W'($urandom), W'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        drain("rand_drain", 200);

        // Reset with four operations in flight.
        for (int r = 0; r < 4; r++) begin
            set_in(W'($urandom), W'($urandom), 1'($urandom));
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("inflight", exp_q.size(), 4);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_bout", bout, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        exp_q.delete();
        cycle();
        arst_n = 1'b1;
        repeat (12) cycle();
        set_in(8'h33, 8'h44, 1'b1);
        in_valid = 1'b1;
        cycle();
        chk("post_rst_accept", accepted, 1'b1);
        drain("post_rst_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
